// File: rtl/bcd2bin_seq.sv
// Sequential packed-BCD to binary converter, one digit per clock, MSD first.
// Optional digit range check enabled by defining BCD2BIN_DIGIT_CHECK_EN.
module bcd2bin_seq #(
   parameter int DIGITS = 4,
   parameter int BIN_W  = 14
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [BIN_W-1:0]      bin_out,
   output logic                  err
);

   localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t              state;
   logic [4*DIGITS-1:0] shreg;
   logic [BIN_W-1:0]    acc;
   logic [CNT_W-1:0]    cnt;
   logic [3:0]          digit;
   logic [BIN_W-1:0]    sum;

   // acc*10 + d as two shifts and adds; wraps modulo 2^BIN_W
   assign digit    = shreg[4*DIGITS-1 -: 4];
   assign sum      = (acc << 3) + (acc << 1) + BIN_W'(digit);
   assign in_ready = (state == IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         bin_out   <= '0;
         acc       <= '0;
         cnt       <= '0;
         shreg     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  shreg <= bcd_in;
                  acc   <= '0;
                  cnt   <= CNT_W'(DIGITS - 1);
                  state <= CONV;
               end
            end
            CONV: begin
               acc   <= sum;
               shreg <= shreg << 4;
               cnt   <= cnt - CNT_W'(1);
               if (cnt == '0) begin
                  bin_out   <= sum;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef BCD2BIN_DIGIT_CHECK_EN
   logic flag;
   logic flag_next;

   // Sticky over one conversion; err is published together with bin_out
   assign flag_next = flag | (digit > 4'd9);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flag <= 1'b0;
         err  <= 1'b0;
      end else if (state == IDLE && in_valid) begin
         flag <= 1'b0;
      end else if (state == CONV) begin
         flag <= flag_next;
         if (cnt == '0) err <= flag_next;
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq: default 4-digit instance and a 2-digit/7-bit instance.
module tb_bcd2bin_seq;

`ifdef BCD2BIN_DIGIT_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_err;
   logic [15:0] a_bcd;
   logic [13:0] a_bin;
   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_err;
   logic [7:0]  b_bcd;
   logic [6:0]  b_bin;
   int          total;
   int          bad;

   bcd2bin_seq dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .bcd_in(a_bcd), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .bin_out(a_bin), .err(a_err)
   );

   bcd2bin_seq #(.DIGITS(2), .BIN_W(7)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .bcd_in(b_bcd), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .bin_out(b_bin), .err(b_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: weighted digit sum with raw nibble values, reduced modulo 2^binw
   function automatic int refVal(input logic [63:0] bcd, input int digits, input int binw);
      longint acc = 0;
      longint p = 1;
      for (int i = 0; i < digits; i++) begin
         acc += longint'(bcd[4*i +: 4]) * p;
         p *= 10;
      end
      return int'(acc % (longint'(1) << binw));
   endfunction

   function automatic logic refErr(input logic [63:0] bcd, input int digits);
      logic any = 1'b0;
      for (int i = 0; i < digits; i++)
         if (bcd[4*i +: 4] > 4'd9) any = 1'b1;
      return any & CHK;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Accept one word on instance A, optionally hold backpressure with junk input
   task automatic applyStimulus(input logic [15:0] bcd, input int hold);
      int lat = 0;
      int expv = refVal({48'd0, bcd}, 4, 14);
      logic experr = refErr({48'd0, bcd}, 4);
      checkOutput("a_ready_idle", a_in_ready, 1);
      a_in_valid = 1'b1;
      a_bcd = bcd;
      cycle();
      a_in_valid = 1'b0;
      a_bcd = 16'($urandom);
      checkOutput("a_ready_busy", a_in_ready, 0);
      while (!a_out_valid && lat < 12) begin
         cycle();
         lat++;
      end
      checkOutput("a_latency", lat, 4);
      checkOutput("a_bin", a_bin, expv);
      checkOutput("a_err", a_err, experr);
      for (int i = 0; i < hold; i++) begin
         a_in_valid = 1'b1;
         a_bcd = 16'($urandom);
         cycle();
         checkOutput("a_hold_valid", a_out_valid, 1);
         checkOutput("a_hold_bin", a_bin, expv);
         checkOutput("a_hold_ready", a_in_ready, 0);
      end
      a_in_valid = 1'b0;
      a_out_ready = 1'b1;
      cycle();
      a_out_ready = 1'b0;
      checkOutput("a_ret_valid", a_out_valid, 0);
      checkOutput("a_ret_ready", a_in_ready, 1);
      checkOutput("a_keep_bin", a_bin, expv);
   endtask

   task automatic runB(input logic [7:0] bcd);
      int lat = 0;
      checkOutput("b_ready_idle", b_in_ready, 1);
      b_in_valid = 1'b1;
      b_bcd = bcd;
      cycle();
      b_in_valid = 1'b0;
      b_bcd = 8'($urandom);
      while (!b_out_valid && lat < 8) begin
         cycle();
         lat++;
      end
      checkOutput("b_latency", lat, 2);
      checkOutput("b_bin", b_bin, refVal({56'd0, bcd}, 2, 7));
      checkOutput("b_err", b_err, refErr({56'd0, bcd}, 2));
      b_out_ready = 1'b1;
      cycle();
      b_out_ready = 1'b0;
      checkOutput("b_ret_valid", b_out_valid, 0);
   endtask

   function automatic logic [15:0] randBcd();
      logic [15:0] w;
      for (int i = 0; i < 4; i++)
         w[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                   : 4'($urandom_range(0, 9));
      return w;
   endfunction

   initial begin
      int seen;
      total = 0;
      bad = 0;
      a_in_valid = 1'b0; a_out_ready = 1'b0; a_bcd = '0;
      b_in_valid = 1'b0; b_out_ready = 1'b0; b_bcd = '0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_valid", a_out_valid, 0);
      checkOutput("rst_bin", a_bin, 0);
      checkOutput("rst_err", a_err, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rst_ready", a_in_ready, 1);

      $display("[TB] directed conversions");
      applyStimulus(16'h0042, 0);
      applyStimulus(16'h0013, 0);
      applyStimulus(16'h9999, 0);
      applyStimulus(16'h0000, 0);
      applyStimulus(16'h1234, 6);
      applyStimulus(16'h00A5, 0);
      applyStimulus(16'h0007, 0);

      $display("[TB] reset during conversion");
      a_in_valid = 1'b1;
      a_bcd = 16'h5678;
      cycle();
      a_in_valid = 1'b0;
      cycle();
      rst_n = 1'b0;
      #1;
      checkOutput("abort_valid", a_out_valid, 0);
      checkOutput("abort_bin", a_bin, 0);
      checkOutput("abort_ready", a_in_ready, 1);
      cycle();
      cycle();
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         cycle();
         if (a_out_valid) seen++;
      end
      checkOutput("abort_no_result", seen, 0);
      applyStimulus(16'h0021, 0);

      $display("[TB] random conversions");
      for (int i = 0; i < 20; i++)
         applyStimulus(randBcd(), $urandom_range(0, 3));

      $display("[TB] two-digit instance");
      runB(8'h42);
      runB(8'h13);
      runB(8'h99);
      for (int i = 0; i < 6; i++) begin
         logic [15:0] w = randBcd();
         runB(w[7:0]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
